// File: rtl/countdown_timer_if.sv
// Handshake bundle between the game FSM and the countdown timer.
// The FSM side drives start/pause/speed and the start digits.
interface countdown_timer_if;
    logic       Start;
    logic       Pause;
    logic [1:0] Speed;
    logic [3:0] StartTens;
    logic [3:0] StartOnes;
    logic [3:0] TensValue;
    logic [3:0] OnesValue;
    logic       Running;
    logic       Tick;
    logic       Warning;
    logic       TimeUp;
    logic       TimeUpPulse;

    modport master (
        output Start, Pause, Speed, StartTens, StartOnes,
        input  TensValue, OnesValue, Running, Tick,
        input  Warning, TimeUp, TimeUpPulse
    );

    modport slave (
        input  Start, Pause, Speed, StartTens, StartOnes,
        output TensValue, OnesValue, Running, Tick,
        output Warning, TimeUp, TimeUpPulse
    );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD game countdown timer with pause, selectable tick rate,
// low-time warning and time-up flags. All outputs are registered.
module countdown_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int WARN_SECONDS    = 10
) (
    input logic         ClockIn,
    input logic         Resetn,
    countdown_timer_if.slave bus
);
    localparam int PW = $clog2(CLOCK_FREQUENCY);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] reload;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    ld_tens, ld_ones;
    logic [6:0]    value_d;
    logic          tick_q, tick_d;
    logic          pulse_q, pulse_d;
    logic          warn_q, warn_d;
    logic          run_q, done_q;

    always_comb begin
        reload  = PW'((CLOCK_FREQUENCY >> bus.Speed) - 1);
        ld_tens = (bus.StartTens > 4'd9) ? 4'd9 : bus.StartTens;
        ld_ones = (bus.StartOnes > 4'd9) ? 4'd9 : bus.StartOnes;
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        tick_d  = 1'b0;
        pulse_d = 1'b0;
        if (bus.Start) begin
            tens_d  = ld_tens;
            ones_d  = ld_ones;
            presc_d = reload;
            if (ld_tens == 4'd0 && ld_ones == 4'd0) begin
                state_d = DONE;
                pulse_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.Pause) begin
                        state_d = PAUSED;
                    end else if (presc_q == '0) begin
                        presc_d = reload;
                        tick_d  = 1'b1;
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            state_d = DONE;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q - 1'b1;
                    end
                end
                PAUSED: begin
                    if (!bus.Pause) state_d = RUN;
                end
                DONE: begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end
                default: ;
            endcase
        end
    end

    // Warning is judged on the value and state that become visible next cycle
    always_comb begin
        value_d = 7'(tens_d) * 7'd10 + 7'(ones_d);
        warn_d  = (state_d == RUN || state_d == PAUSED)
               && value_d != 7'd0
               && value_d <= 7'(WARN_SECONDS);
    end

    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            presc_q <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            tick_q  <= 1'b0;
            pulse_q <= 1'b0;
            warn_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            tick_q  <= tick_d;
            pulse_q <= pulse_d;
            warn_q  <= warn_d;
            run_q   <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.TensValue   = tens_q;
    assign bus.OnesValue   = ones_q;
    assign bus.Running     = run_q;
    assign bus.Tick        = tick_q;
    assign bus.Warning     = warn_q;
    assign bus.TimeUp      = done_q;
    assign bus.TimeUpPulse = pulse_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random stimulus
// checked every cycle against a seconds-level reference model.
module tb_countdown_timer;
    localparam int CF   = 8;
    localparam int WARN = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer #(
        .CLOCK_FREQUENCY(CF),
        .WARN_SECONDS(WARN)
    ) dut (
        .ClockIn(clk),
        .Resetn(rstn),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int m_mode, m_val, m_left, m_tick, m_pulse;

    task automatic check(input string tag, input logic [31:0] got,
                         input int exp);
        n_chk++;
        if (got === 32'(exp)) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    endtask

    // Seconds remaining plus cycles left until the next decrement
    function automatic void model_edge();
        m_tick  = 0;
        m_pulse = 0;
        if (!rstn) begin
            m_mode = M_IDLE;
            m_val  = 0;
            m_left = 0;
        end else if (bus.Start) begin
            int t, o;
            t = (bus.StartTens > 9) ? 9 : int'(bus.StartTens);
            o = (bus.StartOnes > 9) ? 9 : int'(bus.StartOnes);
            m_val  = t * 10 + o;
            m_left = CF >> bus.Speed;
            if (m_val == 0) begin
                m_mode  = M_DONE;
                m_pulse = 1;
            end else begin
                m_mode = M_RUN;
            end
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (bus.Pause) begin
                        m_mode = M_PAUSED;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_val--;
                            m_tick = 1;
                            m_left = CF >> bus.Speed;
                            if (m_val == 0) begin
                                m_mode  = M_DONE;
                                m_pulse = 1;
                            end
                        end
                    end
                end
                M_PAUSED: if (!bus.Pause) m_mode = M_RUN;
                default: ;
            endcase
        end
    endfunction

    task automatic compare_all();
        int w;
        w = ((m_mode == M_RUN || m_mode == M_PAUSED)
             && m_val > 0 && m_val <= WARN) ? 1 : 0;
        check("tens", 32'(bus.TensValue), m_val / 10);
        check("ones", 32'(bus.OnesValue), m_val % 10);
        check("running", 32'(bus.Running), (m_mode == M_RUN) ? 1 : 0);
        check("tick", 32'(bus.Tick), m_tick);
        check("warning", 32'(bus.Warning), w);
        check("timeup", 32'(bus.TimeUp), (m_mode == M_DONE) ? 1 : 0);
        check("timeup_pulse", 32'(bus.TimeUpPulse), m_pulse);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic load(input int t, input int o);
        bus.StartTens = 4'(t);
        bus.StartOnes = 4'(o);
        bus.Start = 1'b1;
        step(1);
        bus.Start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        bus.Start = 1'b0;
        bus.Pause = 1'b0;
        bus.Speed = 2'd0;
        bus.StartTens = 4'd0;
        bus.StartOnes = 4'd0;
        m_mode = M_IDLE; m_val = 0; m_left = 0; m_tick = 0; m_pulse = 0;
        step(2);
        check("rst_tens", 32'(bus.TensValue), 0);
        check("rst_flags", 32'({bus.Running, bus.Tick, bus.Warning,
                                bus.TimeUp, bus.TimeUpPulse}), 0);
        rstn = 1'b1;
        step(2);

        // 12: first decrement 8 cycles after Start, borrow at 10 -> 09
        load(1, 2);
        step(7);
        check("pre_first_tick", 32'(bus.OnesValue), 2);
        step(1);
        check("first_tick_ones", 32'(bus.OnesValue), 1);
        check("first_tick", 32'(bus.Tick), 1);
        check("warn_above", 32'(bus.Warning), 0);
        step(8);
        check("warn_rise", 32'(bus.Warning), 1);
        step(8);
        check("borrow", 32'({bus.TensValue, bus.OnesValue}), 9);

        // 03 runs out: final tick and pulse coincide
        load(0, 3);
        step(23);
        check("pre_done", 32'(bus.TimeUp), 0);
        step(1);
        check("final_tick", 32'({bus.Tick, bus.TimeUpPulse}), 3);
        check("final_val", 32'({bus.TensValue, bus.OnesValue}), 0);
        check("warn_fall", 32'(bus.Warning), 0);
        step(1);
        check("pulse_once", 32'(bus.TimeUpPulse), 0);
        check("timeup_hold", 32'(bus.TimeUp), 1);
        step(10);

        // pause with prescaler at 5, next tick 6 cycles after release
        load(1, 5);
        step(2);
        bus.Pause = 1'b1;
        step(20);
        check("paused_run", 32'(bus.Running), 0);
        check("paused_val", 32'(bus.OnesValue), 5);
        bus.Pause = 1'b0;
        step(6);
        check("resume_no_tick", 32'(bus.Tick), 0);
        step(1);
        check("resume_tick", 32'(bus.Tick), 1);

        // Speed=10 then back to 00: new period after next reload
        bus.Speed = 2'd2;
        load(2, 0);
        step(2);
        check("fast_tick", 32'(bus.Tick), 1);
        bus.Speed = 2'd0;
        step(2);
        check("old_period", 32'(bus.Tick), 1);
        step(7);
        check("new_period_wait", 32'(bus.Tick), 0);
        step(1);
        check("new_period", 32'(bus.Tick), 1);

        // 00 goes straight to DONE, A/F clamps to 99
        load(0, 0);
        check("zero_pulse", 32'({bus.TimeUp, bus.TimeUpPulse}), 3);
        load(10, 15);
        check("clamp", 32'({bus.TensValue, bus.OnesValue}), 8'h99);

        // reset in RUN at 45
        load(4, 5);
        step(3);
        rstn = 1'b0;
        step(1);
        check("rst_run_val", 32'({bus.TensValue, bus.OnesValue}), 0);
        check("rst_run_flags", 32'({bus.Running, bus.TimeUp}), 0);
        rstn = 1'b1;

        // Start wins over Pause while paused
        load(3, 0);
        bus.Pause = 1'b1;
        step(3);
        bus.StartTens = 4'd2;
        bus.StartOnes = 4'd7;
        bus.Start = 1'b1;
        step(1);
        check("start_over_pause", 32'({bus.Running, bus.TensValue,
                                       bus.OnesValue}), 12'h127);
        bus.Start = 1'b0;
        bus.Pause = 1'b0;
        step(3);

        for (int i = 0; i < 4000; i++) begin
            rstn = ($urandom_range(0, 599) != 0);
            bus.Start = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) bus.Pause = ~bus.Pause;
            if ($urandom_range(0, 99) == 0)
                bus.Speed = 2'($urandom_range(0, 3));
            bus.StartTens = ($urandom_range(0, 3) == 0)
                ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            bus.StartOnes = 4'($urandom_range(0, 15));
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Two-digit BCD game countdown timer. Loads a start time, decrements once per tick down to 00, then flags time-up to the game FSM.
- Is the down-counting counterpart of the up-counting display counter. Its OnesValue/TensValue outputs feed the existing hex_decoder instances for HEX0/HEX1.
- Supports a pause input, selectable tick rate, and a low-time warning output.

Parameters:
- CLOCK_FREQUENCY, 50000000, ClockIn cycles per 1 s tick at Speed=00. Must be ≥8 and divisible by 8.
- WARN_SECONDS, 10, Warning threshold in decimal, 0..99.

Ports:
- ClockIn  input  1  system clock; all logic on its rising edge
- Resetn  input  1  synchronous, active-low reset
- Start  input  1  load StartTens/StartOnes and begin counting (level, sampled each cycle)
- Pause  input  1  level; freezes countdown while high in RUN
- Speed  input  2  tick period = CLOCK_FREQUENCY >> Speed cycles (1 s, 0.5 s, 0.25 s, 0.125 s)
- StartTens  input  4  BCD tens digit of start time
- StartOnes  input  4  BCD ones digit of start time
- TensValue  output  4  current tens digit
- OnesValue  output  4  current ones digit
- Running  output  1  high in RUN state
- Tick  output  1  one-cycle pulse on each decrement
- Warning  output  1  high in RUN/PAUSED while value ≤ WARN_SECONDS and value > 0
- TimeUp  output  1  high in DONE state
- TimeUpPulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (Resetn=0 at an edge) has priority over everything. It forces: state IDLE, digits 0/0, prescaler 0, and all flag outputs 0.
- Start has priority over Pause in every state.
- States and transitions:
  - IDLE: hold digits. Start → load.
  - Load action (any state): latch digits, each clamped to 9 if >9. Prescaler ← period−1.
    - Loaded value ≠ 00 → RUN.
    - Loaded value = 00 → DONE directly, with TimeUpPulse asserted the cycle after Start.
  - RUN: Pause=1 → PAUSED. Otherwise prescaler decrements each cycle. When prescaler==0:
    - prescaler ← period−1 (Speed sampled here, so a Speed change takes effect at the next reload);
    - BCD decrement: ones==0 → ones=9, tens−1; else ones−1;
    - Tick=1 for the next cycle;
    - if pre-decrement value was 01 → DONE, with TimeUpPulse=1 in the same cycle as the final Tick.
  - PAUSED: prescaler and digits frozen; Tick=0. Pause=0 → RUN, resuming from the frozen prescaler value (no reload).
  - DONE: digits held at 00; TimeUp=1 until Start or reset. Start → load/restart.
- Start held high in RUN restarts every cycle, so counting begins after Start deasserts. Restart mid-count discards the remaining time.
- Latency:
  - First decrement is visible exactly `period` cycles after the cycle Start was sampled.
  - Subsequent decrements occur every `period` cycles, excluding paused cycles.
- All outputs are registered.
- Prescaler width = $clog2(CLOCK_FREQUENCY).
- Digits never leave 0..9. No wrap below 00.
- Warning compares tens*10+ones ≤ WARN_SECONDS. Warning=0 in IDLE and DONE.

Test Plan:
- CLOCK_FREQUENCY=8, Speed=00, Start with 1/2 (12) → OnesValue becomes 1 exactly 8 cycles after Start; Tick pulses every 8 cycles; 09 follows 10 (borrow).
- Count from 03 → after third tick, value 00; TimeUp=1; TimeUpPulse high for exactly 1 cycle, coincident with Tick; further cycles show no Tick and value stays 00.
- Pause high for 20 cycles mid-count at prescaler=5 → digits and prescaler frozen, Running=0; after release the next Tick arrives 6 cycles later.
- Speed=10 with CLOCK_FREQUENCY=8 → Tick every 2 cycles. Switch to 00 mid-count → new period applied after the next reload.
- Start with 0/0 → DONE and TimeUpPulse the cycle after. Start with A/F → loads 99. WARN_SECONDS=10, count from 12 → Warning rises when value reads 10, falls at DONE.
- Resetn low in RUN at 45 → next cycle: value 00, IDLE, all flags 0. Start and Pause asserted together in PAUSED → reload and RUN.
